// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher: widths, FSM states, GF(2^8)
// byte arithmetic, S-boxes and the inverse round transforms.
package aes_pkg;
  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

  // MSB index of round key r inside the flat expanded schedule (r=0 at the top).
  function automatic int rk_msb(input int nr, input int r);
    return STATE_W * (nr + 1) - 1 - STATE_W * r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    p = a;
    for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), a);
    return gmul(p, p);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n = row + 4*column, byte 0 in the MSBs.
  function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] inv_sub_bytes(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] add_round_key(input logic [STATE_W-1:0] s,
                                                       input logic [STATE_W-1:0] k);
    return s ^ k;
  endfunction

  function automatic logic [STATE_W-1:0] inv_mix_columns(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction
endpackage

// File: rtl/inv_cipher_iter_inv_round.sv
// Combinational single inverse AES round; skip_mix drops InvMixColumns for the
// last round.
module inv_round
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] round_key,
  input  logic               skip_mix,
  output logic [STATE_W-1:0] result
);
  logic [STATE_W-1:0] keyed;

  assign keyed  = add_round_key(inv_sub_bytes(inv_shift_rows(state)), round_key);
  assign result = skip_mix ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Define INV_CIPHER_ZEROIZE_EN to clear state/key registers on output handshake.
module inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WORD_W*NK-1:0]   i_key,
  input  logic [STATE_W-1:0]     i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [STATE_W-1:0]     o_data,
  output logic                   o_valid,
  input  logic                   i_ready
);
  localparam int CTR_W = $clog2(NR + 1);
  localparam int NW    = 4 * (NR + 1);
  localparam int XK_W  = NW * WORD_W;

  fsm_t               fsm, fsm_next;
  logic [CTR_W-1:0]   ctr;
  logic [STATE_W-1:0] state;
  logic [WORD_W*NK-1:0] key;
  logic [XK_W-1:0]    expanded;
  logic [WORD_W-1:0]  kw [NW];
  logic [WORD_W-1:0]  temp;
  logic [7:0]         rcon;
  logic [CTR_W-1:0]   rk_sel;
  logic [STATE_W-1:0] round_key;
  logic [STATE_W-1:0] round_out;
  logic               accept;
  logic               release_out;

  always_comb begin
    kw       = '{default: '0};
    temp     = '0;
    rcon     = 8'h01;
    expanded = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        kw[i] = key[WORD_W*(NK-i)-1 -: WORD_W];
      end else begin
        temp = kw[i-1];
        if (i % NK == 0) begin
          temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
          rcon = xtime(rcon);
        end else if (NK > 6 && i % NK == 4) begin
          temp = sub_word(temp);
        end
        kw[i] = kw[i-NK] ^ temp;
      end
      expanded[XK_W-1-WORD_W*i -: WORD_W] = kw[i];
    end
  end

  always_comb begin
    rk_sel = '0;
    case (fsm)
      INIT:    rk_sel = CTR_W'(NR);
      ROUND:   rk_sel = ctr;
      default: rk_sel = '0;
    endcase
  end

  assign round_key = expanded[rk_msb(NR, int'(rk_sel)) -: STATE_W];

  inv_round u_inv_round (
    .state     (state),
    .round_key (round_key),
    .skip_mix  (fsm == FINAL),
    .result    (round_out)
  );

  assign o_ready     = (fsm == IDLE) && !i_rst;
  assign o_valid     = (fsm == DONE);
  assign o_data      = state;
  assign accept      = i_valid && o_ready;
  assign release_out = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_next = INIT;
      INIT:    fsm_next = ROUND;
      ROUND:   if (ctr == CTR_W'(1)) fsm_next = FINAL;
      FINAL:   fsm_next = DONE;
      DONE:    if (release_out) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // The state register first holds the ciphertext, then the running round state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctr   <= '0;
      state <= '0;
      key   <= '0;
    end else begin
      case (fsm)
        IDLE: if (accept) begin
          key   <= i_key;
          state <= i_data;
        end
        INIT: begin
          state <= state ^ round_key;
          ctr   <= CTR_W'(NR - 1);
        end
        ROUND: begin
          state <= round_out;
          ctr   <= ctr - 1'b1;
        end
        FINAL: state <= round_out;
        DONE: begin
`ifdef INV_CIPHER_ZEROIZE_EN
          if (release_out) begin
            state <= '0;
            key   <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench for inv_cipher_iter: FIPS-197 vectors for all key sizes,
// latency, backpressure, busy input, back-to-back blocks and mid-run reset.
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst, ready;

  logic [127:0] key4, data4, out4;
  logic         valid4, rdy4, ov4;
  logic [191:0] key6;
  logic [127:0] data6, out6;
  logic         valid6, rdy6, ov6;
  logic [255:0] key8;
  logic [127:0] data8, out8;
  logic         valid8, rdy8, ov8;

  int compared   = 0;
  int mismatched = 0;
  int n, outs, lat6, lat8, highs;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
`ifdef INV_CIPHER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  always #5 clk = ~clk;

  inv_cipher_iter #(.NK(4), .NR(10)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_key(key4), .i_data(data4), .i_valid(valid4),
    .o_ready(rdy4), .o_data(out4), .o_valid(ov4), .i_ready(ready));
  inv_cipher_iter #(.NK(6), .NR(12)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_key(key6), .i_data(data6), .i_valid(valid6),
    .o_ready(rdy6), .o_data(out6), .o_valid(ov6), .i_ready(ready));
  inv_cipher_iter #(.NK(8), .NR(14)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_key(key8), .i_data(data8), .i_valid(valid8),
    .o_ready(rdy8), .o_data(out8), .o_valid(ov8), .i_ready(ready));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block4(input string tag, input logic [127:0] k,
                            input logic [127:0] ct, input logic [127:0] pt);
    int w;
    w = 0;
    while (!rdy4 && w < 50) begin step(); w++; end
    check({tag, "_ready"}, 128'(rdy4), 128'd1);
    ready  = 1'b1;
    key4   = k;
    data4  = ct;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    data4  = ~ct;
    w = 0;
    while (!ov4 && w < 40) begin step(); w++; end
    check({tag, "_latency"}, 128'(w), 128'd11);
    check({tag, "_data"}, out4, pt);
    step();
    check({tag, "_valid_drop"}, 128'(ov4), 128'd0);
    check({tag, "_idle_ready"}, 128'(rdy4), 128'd1);
    check({tag, "_idle_data"}, out4, ZEROIZE ? 128'h0 : pt);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1;
    valid4 = 1'b0; valid6 = 1'b0; valid8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    data4 = '0; data6 = '0; data8 = '0;

    // Reset state
    step();
    step();
    check("rst_ready_forced", 128'(rdy4), 128'd0);
    check("rst_valid", 128'(ov4), 128'd0);
    check("rst_data", out4, 128'h0);
    rst = 1'b0;
    #1;
    check("rst_release_ready4", 128'(rdy4), 128'd1);
    check("rst_release_ready6", 128'(rdy6), 128'd1);
    check("rst_release_ready8", 128'(rdy8), 128'd1);

    run_block4("fips_b", KEY_B, CT_B, PT_B);

    // AES-192 and AES-256 in parallel
    key6   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    key8   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    data6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    data8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    valid6 = 1'b1;
    valid8 = 1'b1;
    step();
    valid6 = 1'b0;
    valid8 = 1'b0;
    lat6 = -1; lat8 = -1; n = 0;
    while ((lat6 < 0 || lat8 < 0) && n < 40) begin
      step();
      n++;
      if (ov6 && lat6 < 0) begin lat6 = n; check("aes192_data", out6, PT_C); end
      if (ov8 && lat8 < 0) begin lat8 = n; check("aes256_data", out8, PT_C); end
    end
    check("aes192_latency", 128'(lat6), 128'd13);
    check("aes256_latency", 128'(lat8), 128'd15);
    step();

    // Backpressure in DONE while a new block is offered
    ready  = 1'b0;
    key4   = KEY_C;
    data4  = CT_C;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    n = 0;
    while (!ov4 && n < 40) begin step(); n++; end
    check("bp_latency", 128'(n), 128'd11);
    for (int i = 0; i < 20; i++) begin
      valid4 = 1'b1;
      data4  = rand128();
      key4   = rand128();
      step();
      check("bp_valid_held", 128'(ov4), 128'd1);
      check("bp_data_held", out4, PT_C);
      check("bp_ready_low", 128'(rdy4), 128'd0);
    end
    valid4 = 1'b0;
    ready  = 1'b1;
    step();
    check("bp_release_valid", 128'(ov4), 128'd0);
    check("bp_release_ready", 128'(rdy4), 128'd1);
    check("bp_idle_data", out4, ZEROIZE ? 128'h0 : PT_C);

    // Busy input with changing data, then back-to-back accept
    key4   = KEY_C;
    data4  = CT_C;
    valid4 = 1'b1;
    step();
    n = 0; outs = 0;
    while (!rdy4 && n < 40) begin
      if (n < 10) begin
        data4 = rand128();
        key4  = rand128();
      end else begin
        data4 = CT_C;
        key4  = KEY_C;
      end
      step();
      n++;
      if (ov4) begin
        outs++;
        check("b2b_first_latency", 128'(n), 128'd11);
        check("b2b_first_data", out4, PT_C);
      end
    end
    check("b2b_first_outputs", 128'(outs), 128'd1);
    check("b2b_accept_interval", 128'(n + 1), 128'd13);
    step();
    valid4 = 1'b0;
    n = 0;
    while (!ov4 && n < 40) begin step(); n++; end
    check("b2b_second_latency", 128'(n), 128'd11);
    check("b2b_second_data", out4, PT_C);
    step();

    // Reset while in ROUND with ctr=5
    key4   = KEY_B;
    data4  = CT_B;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_prevalid", 128'(ov4), 128'd0);
    rst = 1'b1;
    #1;
    check("abort_ready_forced", 128'(rdy4), 128'd0);
    step();
    check("abort_valid", 128'(ov4), 128'd0);
    check("abort_data", out4, 128'h0);
    rst = 1'b0;
    #1;
    check("abort_ready", 128'(rdy4), 128'd1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov4) highs++;
    end
    check("abort_no_stale", 128'(highs), 128'd0);
    run_block4("post_abort", KEY_B, CT_B, PT_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/inv_cipher_iter.md
Name: inv_cipher_iter

Overview:
- Iterative AES inverse cipher (decryption) for FIPS-197: one 128-bit ciphertext block per transaction, one round per clock.
- Counterpart to the combinational encryption datapath. Shares key_expansion and add_round_key with it, plus the inverse byte transforms.
- Valid/ready handshakes on input and output. Sits between the ciphertext source and the plaintext sink.

Parameters:
- NK, 4, number of 32-bit words in the key (4/6/8)
- NR, 10, number of rounds (10/12/14; must match NK)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous reset, active-high
- i_key  input  32*NK  cipher key, sampled on input handshake
- i_data  input  128  ciphertext, sampled on input handshake
- i_valid  input  1  input block valid
- o_ready  output  1  block can accept input
- o_data  output  128  plaintext; meaningful only while o_valid=1
- o_valid  output  1  plaintext valid
- i_ready  input  1  downstream accepts plaintext

Behaviour:
- Reset (i_rst=1 at an edge): FSM=IDLE, round counter=0, state/key registers=0. o_valid=0, o_data=0. o_ready is forced 0 while i_rst=1.
- Reset mid-operation aborts the block: no output is produced and the block returns to IDLE.
- Round keys: key_expansion is driven from the latched key register. Round key r = expanded[(4*(NR+1)*32)-1-128*r -:128], with r=0 taking the MSBs.
- FSM: IDLE -> INIT -> ROUND -> FINAL -> DONE.
- IDLE: o_ready=1. On i_valid&&o_ready: latch i_key and i_data, go to INIT. i_valid without a handshake changes nothing.
- INIT: state <= data ^ rk[NR]; ctr <= NR-1; go to ROUND.
- ROUND: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[ctr]); ctr <= ctr-1. After processing ctr==1, go to FINAL.
- FINAL: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go to DONE.
- DONE: o_valid=1 and o_data=state; both held stable until i_ready=1. On o_valid&&i_ready: go to IDLE, o_valid=0 next cycle.
- Latency: o_valid rises NR+1 cycles after the input-handshake edge (11/13/15).
- Minimum interval between input accepts: NR+3 cycles with i_ready held high.
- o_ready=0 in every state except IDLE. Input presented during a busy period is not consumed; i_data/i_key are ignored until the next handshake.
- Backpressure: i_ready low in DONE stalls the block indefinitely with no state change.
- Counter width: clog2(NR+1). Never wraps, because ROUND exits at ctr==1.
- i_ready outside DONE has no effect.

Optional Feature:
- Macro INV_CIPHER_ZEROIZE_EN.
- When defined: on the output handshake, data/state and key registers clear to 0 on the same edge that enters IDLE. o_data reads 0 in IDLE.
- When undefined: registers retain contents. o_data holds the last plaintext in IDLE.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - state-width constant (128) and word width (32)
  - FSM state enum: IDLE, INIT, ROUND, FINAL, DONE
  - round-key slice helper constant/function for a given NR
- Natural sub-module: inv_round, a combinational single inverse round.
  - Inputs: state, round key, skip_mix flag.
  - Built from inv_shift_rows, inv_sub_bytes, add_round_key and inv_mix_columns.
  - Reused by both ROUND and FINAL via skip_mix.

Test Plan:
- NK=4/NR=10: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, i_ready=1 -> o_data 3243f6a8885a308d313198a2e0370734; o_valid exactly 11 cycles after the handshake.
- NK=6/NR=12 key 000102..17 with ct dda97ca4864cdfe06eaf70a0ec0d7191, and NK=8/NR=14 key 000102..1f with ct 8ea2b7ca516745bfeafc49904b496089 -> o_data 00112233445566778899aabbccddeeff in both; latency 13/15.
- Backpressure: i_ready=0 for 20 cycles in DONE -> o_valid and o_data (00112233...eeff) stable throughout. o_ready=0; a new i_valid is not accepted. Handshake on i_ready=1 -> IDLE next cycle.
- Busy input: i_valid held high with changing i_data during rounds -> only the first block is consumed. Back-to-back blocks 69c4e0d86a7b0430d8cdb78070b4c55a under key 000102..0f -> two outputs of 00112233...eeff, handshakes NR+3 cycles apart.
- Reset at ROUND (ctr=5) -> next cycle o_valid=0, o_data=0, then o_ready=1 after i_rst drops. No stale output is emitted. A new block decrypts correctly.
- Zeroize build: after the output handshake, o_data==0 in IDLE. Non-zeroize build: o_data holds 00112233...eeff.
